// File: rtl/rx_block_lock_pkg.sv
// Shared PCS receive definitions: sync header codes, block-lock FSM states
// and the header-validity helper used by the block-lock logic.
package rx_block_lock_pkg;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {
    LOCK_TEST      = 2'd0,
    LOCK_SLIP      = 2'd1,
    LOCK_SLIP_WAIT = 2'd2
  } lock_state_t;

  function automatic logic sync_hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock_if.sv
// Beat stream between PCS receive stages: one data beat plus the sync header
// that is meaningful on the first beat of each 66b block.
interface rx_block_lock_if #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
);

  logic [DATA_WIDTH-1:0] data;
  logic [HDR_WIDTH-1:0]  sync_hdr;
  logic                  data_valid;

  modport master (output data, output sync_hdr, output data_valid);
  modport slave  (input  data, input  sync_hdr, input  data_valid);

endinterface

// File: rtl/rx_block_lock_chk.sv
// Protocol checks on the block-lock outputs: a slip is a single-cycle pulse
// and is never issued while lock is reported.
module rx_block_lock_chk (
  input logic clk,
  input logic rst_n,
  input logic slip,
  input logic lock
);

  slip_single_cycle: assert property (@(posedge clk) disable iff (!rst_n) slip |=> !slip);

  slip_implies_unlocked: assert property (@(posedge clk) disable iff (!rst_n) slip |-> !lock);

endmodule

// File: rtl/rx_block_lock.sv
// 66b block-lock state machine: hunts for sync header alignment by slipping
// block_sync, reports block lock and forwards beats qualified by lock.
module rx_block_lock
  import rx_block_lock_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int HDR_WIDTH        = 2,
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVLD_MAX     = 16,
  parameter int SLIP_WAIT_CYCLES = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  rx_block_lock_if.slave  rx_in,
  rx_block_lock_if.master rx_out,
  output logic            o_slip,
  output logic            o_block_lock
);

  localparam int SH_CNT_W = $clog2(SH_CNT_MAX) + 1;
  localparam int INVLD_W  = $clog2(SH_INVLD_MAX) + 1;
  localparam int WAIT_W   = $clog2(SLIP_WAIT_CYCLES) + 1;

  localparam logic [SH_CNT_W-1:0] SH_CNT_LIMIT   = SH_CNT_W'(SH_CNT_MAX);
  localparam logic [SH_CNT_W-1:0] SH_CNT_ONE     = SH_CNT_W'(1);
  localparam logic [SH_CNT_W-1:0] SH_CNT_ZERO    = SH_CNT_W'(0);
  localparam logic [INVLD_W-1:0]  INVLD_LIMIT    = INVLD_W'(SH_INVLD_MAX);
  localparam logic [INVLD_W-1:0]  INVLD_ONE      = INVLD_W'(1);
  localparam logic [INVLD_W-1:0]  INVLD_ZERO     = INVLD_W'(0);
  localparam logic [WAIT_W-1:0]   WAIT_LAST      = WAIT_W'(SLIP_WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0]   WAIT_ONE       = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]   WAIT_ZERO      = WAIT_W'(0);

  lock_state_t           state_q,        state_d;
  logic [SH_CNT_W-1:0]   sh_cnt_q,       sh_cnt_d;
  logic [INVLD_W-1:0]    sh_invld_cnt_q, sh_invld_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q,     wait_cnt_d;
  logic                  beat_flag_q,    beat_flag_d;
  logic                  slip_q,         slip_d;
  logic                  lock_q,         lock_d;
  logic [DATA_WIDTH-1:0] data_q,         data_d;
  logic [HDR_WIDTH-1:0]  hdr_q,          hdr_d;
  logic                  valid_q,        valid_d;

  logic                  hdr_beat_s;
  logic                  hdr_ok_s;
  logic [INVLD_W-1:0]    invld_inc_s;

  // Next-state logic for the lock FSM, header counters and forwarding stage.
  always_comb begin
    hdr_beat_s     = rx_in.data_valid & ~beat_flag_q;
    hdr_ok_s       = sync_hdr_valid(rx_in.sync_hdr);
    invld_inc_s    = sh_invld_cnt_q + INVLD_ONE;

    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    beat_flag_d    = beat_flag_q ^ rx_in.data_valid;
    slip_d         = 1'b0;
    lock_d         = lock_q;

    case (state_q)
      LOCK_TEST: begin
        // sh_cnt sits at the limit for exactly one cycle: the window verdict.
        if (sh_cnt_q == SH_CNT_LIMIT) begin
          sh_cnt_d       = SH_CNT_ZERO;
          sh_invld_cnt_d = INVLD_ZERO;
          if (sh_invld_cnt_q == INVLD_ZERO) begin
            lock_d = 1'b1;
          end else begin
            lock_d = lock_q;
          end
        end else if (hdr_beat_s) begin
          sh_cnt_d = sh_cnt_q + SH_CNT_ONE;
          if (hdr_ok_s) begin
            sh_invld_cnt_d = sh_invld_cnt_q;
          end else if (!lock_q || (invld_inc_s == INVLD_LIMIT)) begin
            state_d = LOCK_SLIP;
            slip_d  = 1'b1;
            lock_d  = 1'b0;
          end else begin
            sh_invld_cnt_d = invld_inc_s;
          end
        end else begin
          sh_cnt_d = sh_cnt_q;
        end
      end

      LOCK_SLIP: begin
        state_d        = LOCK_SLIP_WAIT;
        lock_d         = 1'b0;
        sh_cnt_d       = SH_CNT_ZERO;
        sh_invld_cnt_d = INVLD_ZERO;
        beat_flag_d    = 1'b0;
        wait_cnt_d     = WAIT_ZERO;
      end

      LOCK_SLIP_WAIT: begin
        // block_sync is realigning; its output is ignored for lock purposes.
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = LOCK_TEST;
          wait_cnt_d = WAIT_ZERO;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end

      default: begin
        state_d        = LOCK_TEST;
        lock_d         = 1'b0;
        sh_cnt_d       = SH_CNT_ZERO;
        sh_invld_cnt_d = INVLD_ZERO;
        beat_flag_d    = 1'b0;
        wait_cnt_d     = WAIT_ZERO;
      end
    endcase

    data_d = rx_in.data;
    if (hdr_beat_s) begin
      hdr_d = rx_in.sync_hdr;
    end else begin
      hdr_d = hdr_q;
    end
    valid_d = rx_in.data_valid & lock_q & (state_q == LOCK_TEST);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= LOCK_TEST;
      sh_cnt_q       <= SH_CNT_ZERO;
      sh_invld_cnt_q <= INVLD_ZERO;
      wait_cnt_q     <= WAIT_ZERO;
      beat_flag_q    <= 1'b0;
      slip_q         <= 1'b0;
      lock_q         <= 1'b0;
      data_q         <= {DATA_WIDTH{1'b0}};
      hdr_q          <= {HDR_WIDTH{1'b0}};
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      beat_flag_q    <= beat_flag_d;
      slip_q         <= slip_d;
      lock_q         <= lock_d;
      data_q         <= data_d;
      hdr_q          <= hdr_d;
      valid_q        <= valid_d;
    end
  end

  assign o_slip            = slip_q;
  assign o_block_lock      = lock_q;
  assign rx_out.data       = data_q;
  assign rx_out.sync_hdr   = hdr_q;
  assign rx_out.data_valid = valid_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock: lock acquisition, slip timing, invalid
// header windows, reset during slip wait and forwarding with valid gaps.
module tb_rx_block_lock;
  import rx_block_lock_pkg::*;

  localparam int DW = 32;
  localparam int HW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [HW-1:0] hdr;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic slip;
  logic lock;

  always #5 clk = ~clk;

  rx_block_lock_if #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) in_if ();
  rx_block_lock_if #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) out_if ();

  rx_block_lock #(
    .DATA_WIDTH(DW), .HDR_WIDTH(HW), .SH_CNT_MAX(64), .SH_INVLD_MAX(16), .SLIP_WAIT_CYCLES(32)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .rx_in(in_if), .rx_out(out_if),
    .o_slip(slip), .o_block_lock(lock)
  );

  rx_block_lock_chk u_chk (.clk(clk), .rst_n(rst_n), .slip(slip), .lock(lock));

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int hdr_cyc = 0;
  int slip_cnt = 0;
  int last_slip_cyc = -1;
  int lock_rise_cyc = -1;
  int lock_fall_cyc = -1;
  int fwd_cnt = 0;
  bit prev_slip = 1'b0;
  bit prev_lock = 1'b0;
  bit slip_double = 1'b0;
  bit ref_en = 1'b0;
  beat_t ref_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observer on the falling edge: slip/lock events and the forwarded-beat reference.
  initial forever begin
    beat_t exp_b;
    @(negedge clk);
    if (slip) begin
      slip_cnt++;
      last_slip_cyc = cyc;
      if (prev_slip) slip_double = 1'b1;
    end
    if (lock && !prev_lock) lock_rise_cyc = cyc;
    if (!lock && prev_lock) lock_fall_cyc = cyc;
    prev_slip = slip;
    prev_lock = lock;
    if (ref_en && out_if.data_valid) begin
      fwd_cnt++;
      check_val("ref_avail", 32'(ref_q.size() != 0), 32'd1);
      if (ref_q.size() != 0) begin
        exp_b = ref_q.pop_front();
        check_val("fwd_data", out_if.data, exp_b.data);
        check_val("fwd_hdr", 32'(out_if.sync_hdr), 32'(exp_b.hdr));
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] h, input logic [31:0] d);
    @(negedge clk);
    in_if.data_valid = v;
    in_if.sync_hdr   = h;
    in_if.data       = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 32'hA5A5_0000 + 32'(i + 1));
  endtask

  // Optional leading gap, header beat, gap, data beat (data-beat header is garbage 11).
  task automatic send_block(input logic [1:0] h, input int gap, input bit track);
    logic [31:0] d0;
    logic [31:0] d1;
    d0 = $urandom;
    d1 = $urandom;
    idle(gap);
    drive(1'b1, h, d0);
    hdr_cyc = cyc + 1;
    if (track) ref_q.push_back('{data: d0, hdr: h});
    idle(gap);
    drive(1'b1, 2'b11, d1);
    if (track) ref_q.push_back('{data: d1, hdr: h});
  endtask

  task automatic send_good(input int n, input int gap);
    for (int i = 0; i < n; i++) send_block((i % 2 == 1) ? SYNC_HDR_CTRL : SYNC_HDR_DATA, gap, 1'b0);
  endtask

  task automatic send_window(input int lo, input int hi);
    for (int i = 0; i < 64; i++)
      send_block((i >= lo && i <= hi) ? 2'b11 : ((i % 2 == 1) ? SYNC_HDR_CTRL : SYNC_HDR_DATA), 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    int rel_cyc;
    int h;
    rst_n = 1'b0;
    in_if.data_valid = 1'b1;
    in_if.sync_hdr   = SYNC_HDR_DATA;
    in_if.data       = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check_val("rst_lock", 32'(lock), 32'd0);
    check_val("rst_slip", 32'(slip), 32'd0);
    check_val("rst_valid", 32'(out_if.data_valid), 32'd0);
    check_val("rst_data", out_if.data, 32'd0);
    check_val("rst_hdr", 32'(out_if.sync_hdr), 32'd0);
    in_if.data_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // 1: 64 good blocks lock one cycle after the 64th header.
    s0 = slip_cnt;
    send_good(1, 0);
    check_val("t1_gate", 32'(out_if.data_valid), 32'd0);
    send_good(63, 0);
    check_val("t1_lock_early", 32'(lock), 32'd0);
    idle(2);
    check_val("t1_lock_lat", 32'(lock_rise_cyc), 32'(hdr_cyc + 1));
    check_val("t1_lock", 32'(lock), 32'd1);
    check_val("t1_no_slip", 32'(slip_cnt), 32'(s0));
    send_good(1, 0);
    check_val("t1_fwd_valid", 32'(out_if.data_valid), 32'd1);

    // 2: unlocked, bad header at block 10 slips once; slip wait ignores input.
    do_reset();
    send_good(9, 0);
    s0 = slip_cnt;
    send_block(2'b00, 0, 1'b0);
    h = hdr_cyc;
    check_val("t2_slip_hi", 32'(slip), 32'd1);
    check_val("t2_lock_lo", 32'(lock), 32'd0);
    idle(1);
    check_val("t2_slip_lo", 32'(slip), 32'd0);
    for (int i = 0; i < 14; i++) send_block(2'b00, 0, 1'b0);
    idle(2);
    send_block(2'b00, 0, 1'b0);
    check_val("t2_last_wait_hdr", 32'(hdr_cyc), 32'(h + 33));
    idle(2);
    check_val("t2_wait_ignore", 32'(slip_cnt), 32'(s0 + 1));
    send_block(2'b00, 0, 1'b0);
    idle(2);
    check_val("t2_slip2_cnt", 32'(slip_cnt), 32'(s0 + 2));
    check_val("t2_slip2_cyc", 32'(last_slip_cyc), 32'(hdr_cyc));
    idle(40);
    send_good(64, 0);
    idle(2);
    check_val("t2_relock_lat", 32'(lock_rise_cyc), 32'(hdr_cyc + 1));
    check_val("t2_relock", 32'(lock), 32'd1);

    // 3: 15 invalid per window holds lock; the 16th slips and drops lock together.
    s0 = slip_cnt;
    send_window(10, 24);
    idle(2);
    check_val("t3_win_lock", 32'(lock), 32'd1);
    check_val("t3_win_noslip", 32'(slip_cnt), 32'(s0));
    for (int i = 0; i < 15; i++) send_block(2'b11, 0, 1'b0);
    check_val("t3_15_hold", 32'(lock), 32'd1);
    check_val("t3_15_noslip", 32'(slip), 32'd0);
    send_block(2'b11, 0, 1'b0);
    check_val("t3_slip16", 32'(slip), 32'd1);
    check_val("t3_lock_drop", 32'(lock), 32'd0);
    idle(2);
    check_val("t3_fall_cyc", 32'(lock_fall_cyc), 32'(hdr_cyc));

    // 4: three windows of 15 invalid keep lock; 64th header as 16th invalid slips.
    idle(40);
    send_good(64, 0);
    idle(2);
    check_val("t4_lock", 32'(lock), 32'd1);
    s0 = slip_cnt;
    send_window(0, 14);
    check_val("t4_w1_lock", 32'(lock), 32'd1);
    send_window(20, 34);
    check_val("t4_w2_lock", 32'(lock), 32'd1);
    send_window(49, 63);
    idle(2);
    check_val("t4_w3_lock", 32'(lock), 32'd1);
    check_val("t4_noslip", 32'(slip_cnt), 32'(s0));
    send_window(48, 63);
    check_val("t4_sim_slip", 32'(slip), 32'd1);
    check_val("t4_sim_lock", 32'(lock), 32'd0);

    // 5: asynchronous reset in slip wait clears outputs at once; relock timing exact.
    idle(10);
    check_val("t5_pre_data", 32'(out_if.data != 32'd0), 32'd1);
    check_val("t5_pre_hdr", 32'(out_if.sync_hdr), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_rst_lock", 32'(lock), 32'd0);
    check_val("t5_rst_slip", 32'(slip), 32'd0);
    check_val("t5_rst_valid", 32'(out_if.data_valid), 32'd0);
    check_val("t5_rst_data", out_if.data, 32'd0);
    check_val("t5_rst_hdr", 32'(out_if.sync_hdr), 32'd0);
    idle(2);
    rst_n = 1'b1;
    rel_cyc = cyc;
    s0 = slip_cnt;
    send_good(64, 0);
    idle(2);
    check_val("t5_relock_cyc", 32'(lock_rise_cyc), 32'(rel_cyc + 129));
    check_val("t5_no_slip", 32'(slip_cnt), 32'(s0));

    // 6: valid gaps of 1-3 cycles; forwarded beats follow the reference queue.
    do_reset();
    for (int i = 0; i < 64; i++) send_block((i % 2 == 1) ? SYNC_HDR_CTRL : SYNC_HDR_DATA, (i % 3) + 1, 1'b0);
    idle(2);
    check_val("t6_lock_lat", 32'(lock_rise_cyc), 32'(hdr_cyc + 1));
    idle(3);
    ref_en = 1'b1;
    fwd_cnt = 0;
    for (int i = 0; i < 500; i++)
      send_block(((i * 5) % 3 == 1) ? SYNC_HDR_CTRL : SYNC_HDR_DATA, ((i * 7) % 3) + 1, 1'b1);
    idle(3);
    ref_en = 1'b0;
    check_val("t6_fwd_cnt", 32'(fwd_cnt), 32'd1000);
    check_val("t6_ref_empty", 32'(ref_q.size()), 32'd0);
    check_val("t6_lock", 32'(lock), 32'd1);
    check_val("slip_two_cyc", 32'(slip_double), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
